// File: rtl/weight_comp_input_feeder_pkg.sv
// Shared definitions for the weight-comparison input feeder and the cell chain it drives:
// feeder states, counter sizing helpers and the lane slice macro.
`ifndef WEIGHT_COMP_LANE_MACRO
`define WEIGHT_COMP_LANE_MACRO
`define WC_LANE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package weight_comp_input_feeder_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } feed_state_t;

    function automatic int chunk_count(input int weights, input int inputs);
        return weights / inputs;
    endfunction

    // A counter over n values needs at least one bit even when n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_comp_input_feeder.sv
// Packs a serial word stream into INPUT_AMOUNT-wide chunks tagged with their weight index,
// zero-padding short vectors so each vector always spans WEIGHT_AMOUNT/INPUT_AMOUNT chunks.
module weight_comp_input_feeder
    import weight_comp_input_feeder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHT_AMOUNT = 8,
    parameter int INPUT_AMOUNT  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [DATA_WIDTH-1:0]              output_index,
    output logic [INPUT_AMOUNT*DATA_WIDTH-1:0] output_value,
    output logic                               output_enable,
    output logic                               busy
);

    localparam int CHUNKS = chunk_count(WEIGHT_AMOUNT, INPUT_AMOUNT);
    localparam int LANE_W = cnt_width(INPUT_AMOUNT);
    localparam int IDX_W  = cnt_width(CHUNKS);
    localparam int VEC_W  = INPUT_AMOUNT * DATA_WIDTH;

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(INPUT_AMOUNT - 1);
    localparam logic [IDX_W-1:0]  LAST_CHUNK = IDX_W'(CHUNKS - 1);

    feed_state_t             state, state_nxt;
    logic [LANE_W-1:0]       lane_cnt, lane_nxt;
    logic [IDX_W-1:0]        chunk_idx, idx_nxt, idx_step;
    logic [VEC_W-1:0]        chunk, chunk_nxt, filled;
    logic [DATA_WIDTH-1:0]   index_nxt, chunk_base;
    logic [VEC_W-1:0]        value_nxt;
    logic                    enable_nxt;
    logic                    accept;

    assign in_ready   = (state == FILL);
    assign busy       = (lane_cnt != '0) || (state == PAD);
    assign accept     = in_valid && (state == FILL);
    assign chunk_base = DATA_WIDTH'(chunk_idx) * DATA_WIDTH'(INPUT_AMOUNT);
    assign idx_step   = (chunk_idx == LAST_CHUNK) ? '0 : chunk_idx + IDX_W'(1);

    always_comb begin
        state_nxt  = state;
        lane_nxt   = lane_cnt;
        idx_nxt    = chunk_idx;
        chunk_nxt  = chunk;
        index_nxt  = output_index;
        value_nxt  = output_value;
        enable_nxt = 1'b0;
        filled     = chunk;

        // Lanes above lane_cnt are still zero because the chunk register clears on every emit.
        for (int k = 0; k < INPUT_AMOUNT; k++) begin
            if (LANE_W'(k) == lane_cnt) begin
                `WC_LANE(filled, k, DATA_WIDTH) = in_data;
            end
        end

        case (state)
            FILL: begin
                if (accept) begin
                    if (lane_cnt == LAST_LANE || in_last) begin
                        index_nxt  = chunk_base;
                        value_nxt  = filled;
                        enable_nxt = 1'b1;
                        lane_nxt   = '0;
                        chunk_nxt  = '0;
                        idx_nxt    = idx_step;
                        if (in_last && chunk_idx != LAST_CHUNK) begin
                            state_nxt = PAD;
                        end
                    end else begin
                        chunk_nxt = filled;
                        lane_nxt  = lane_cnt + LANE_W'(1);
                    end
                end
            end
            PAD: begin
                index_nxt  = chunk_base;
                value_nxt  = '0;
                enable_nxt = 1'b1;
                idx_nxt    = idx_step;
                if (chunk_idx == LAST_CHUNK) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FILL;
            lane_cnt      <= '0;
            chunk_idx     <= '0;
            chunk         <= '0;
            output_index  <= '0;
            output_value  <= '0;
            output_enable <= 1'b0;
        end else begin
            state         <= state_nxt;
            lane_cnt      <= lane_nxt;
            chunk_idx     <= idx_nxt;
            chunk         <= chunk_nxt;
            output_index  <= index_nxt;
            output_value  <= value_nxt;
            output_enable <= enable_nxt;
        end
    end

endmodule
